// File: rtl/shift_pkg.sv
// Shared mode encodings for the shift-register family.
// Any block that drives or decodes a 2-bit shift mode should use these names.
package shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a 4:1 mode mux feeding a flop.
// The flop clears asynchronously when clear is low.
module usr_bit_cell
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] mode,
  input  logic       up_in,
  input  logic       dn_in,
  input  logic       load_in,
  output logic       q
);

  logic q_next;

  always_comb begin
    // NOTE: assigning the default first means every path drives q_next, so no latch is inferred.
    q_next = q;
    case (mode)
      MODE_UP:   q_next = up_in;
      MODE_DN:   q_next = dn_in;
      MODE_LOAD: q_next = load_in;
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    // NOTE: sequential state uses non-blocking assignments so all cells update from pre-edge values.
    if (!clear) q <= 1'b0;
    else        q <= q_next;
  end

endmodule

// File: rtl/n_universal_shift_reg.sv
// N-bit universal shift register: hold, shift up, shift down, parallel load,
// with serial outputs at both ends and a word counter that pulses word_valid.
module n_universal_shift_reg
  import shift_pkg::*;
#(
  parameter  int N     = 8,
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             sin_up,
  input  logic             sin_dn,
  input  logic [N-1:0]     d,
  output logic [N-1:0]     Q,
  output logic             sout_up,
  output logic             sout_dn,
  output logic [CNT_W-1:0] count,
  output logic             word_valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [N-1:0] up_nb;
  logic [N-1:0] dn_nb;

  // End cells take the serial inputs; interior cells take their neighbours.
  for (genvar i = 0; i < N; i++) begin : g_cell
    if (i == 0) begin : g_up_end
      assign up_nb[i] = sin_up;
    end else begin : g_up_mid
      assign up_nb[i] = Q[i-1];
    end

    if (i == N - 1) begin : g_dn_end
      assign dn_nb[i] = sin_dn;
    end else begin : g_dn_mid
      assign dn_nb[i] = Q[i+1];
    end

    usr_bit_cell u_cell (
      .clk     (clk),
      .clear   (clear),
      .mode    (mode),
      .up_in   (up_nb[i]),
      .dn_in   (dn_nb[i]),
      .load_in (d[i]),
      .q       (Q[i])
    );
  end

  assign sout_up = Q[N-1];
  assign sout_dn = Q[0];

  // Shifts in either direction accumulate toward the word boundary; loads abort the word.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count      <= '0;
      word_valid <= 1'b0;
    end else begin
      case (mode)
        MODE_UP, MODE_DN: begin
          if (count == LAST) begin
            count      <= '0;
            word_valid <= 1'b1;
          end else begin
            count      <= count + CNT_W'(1);
            word_valid <= 1'b0;
          end
        end
        MODE_LOAD: begin
          count      <= '0;
          word_valid <= 1'b0;
        end
        default: begin
          word_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n_universal_shift_reg.sv
// Self-checking bench for n_universal_shift_reg: an N=4 and an N=1 instance
// compared against an arithmetic model of register contents and word count.
module tb_n_universal_shift_reg;

  logic       clk = 1'b0;
  logic       clear = 1'b0;

  logic [1:0] mode4 = 2'b00;
  logic       sup4 = 1'b0, sdn4 = 1'b0;
  logic [3:0] d4 = '0;
  logic [3:0] q4;
  logic       sout_up4, sout_dn4, wv4;
  logic [1:0] cnt4;

  logic [1:0] mode1 = 2'b00;
  logic       sup1 = 1'b0, sdn1 = 1'b0;
  logic [0:0] d1 = '0;
  logic [0:0] q1;
  logic       sout_up1, sout_dn1, wv1;
  logic [0:0] cnt1;

  int checks = 0;
  int errors = 0;

  int m4_q = 0, m4_cnt = 0; bit m4_wv = 0;
  int m1_q = 0, m1_cnt = 0; bit m1_wv = 0;

  always #5 clk = ~clk;

  n_universal_shift_reg #(.N(4)) dut4 (
    .clk(clk), .clear(clear), .mode(mode4), .sin_up(sup4), .sin_dn(sdn4), .d(d4),
    .Q(q4), .sout_up(sout_up4), .sout_dn(sout_dn4), .count(cnt4), .word_valid(wv4)
  );

  n_universal_shift_reg #(.N(1)) dut1 (
    .clk(clk), .clear(clear), .mode(mode1), .sin_up(sup1), .sin_dn(sdn1), .d(d1),
    .Q(q1), .sout_up(sout_up1), .sout_dn(sout_dn1), .count(cnt1), .word_valid(wv1)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Register as an integer, word progress as shifts modulo N.
  function automatic void model(input int n, input logic [1:0] md, input int su, input int sd,
                                input int dd, inout int q, inout int cnt, inout bit wv);
    int mask;
    mask = (1 << n) - 1;
    case (md)
      2'b00: wv = 1'b0;
      2'b11: begin q = dd & mask; cnt = 0; wv = 1'b0; end
      default: begin
        if (md == 2'b01) q = ((q << 1) | su) & mask;
        else             q = (q >> 1) | (sd << (n - 1));
        cnt = (cnt + 1) % n;
        wv  = (cnt == 0);
      end
    endcase
  endfunction

  task automatic check_all();
    check("q4",       32'(q4),       32'(m4_q));
    check("cnt4",     32'(cnt4),     32'(m4_cnt));
    check("wv4",      32'(wv4),      32'(m4_wv));
    check("sout_up4", 32'(sout_up4), 32'((m4_q >> 3) & 1));
    check("sout_dn4", 32'(sout_dn4), 32'(m4_q & 1));
    check("q1",       32'(q1),       32'(m1_q));
    check("cnt1",     32'(cnt1),     32'(m1_cnt));
    check("wv1",      32'(wv1),      32'(m1_wv));
  endtask

  task automatic model_reset();
    m4_q = 0; m4_cnt = 0; m4_wv = 1'b0;
    m1_q = 0; m1_cnt = 0; m1_wv = 1'b0;
  endtask

  // Apply current inputs for one edge, then sample 1 time unit later.
  task automatic step(input logic [1:0] md, input logic su, input logic sd, input logic [3:0] dd);
    mode4 = md; sup4 = su; sdn4 = sd; d4 = dd;
    @(posedge clk);
    #1;
    model(4, mode4, int'(sup4), int'(sdn4), int'(d4), m4_q, m4_cnt, m4_wv);
    model(1, mode1, int'(sup1), int'(sdn1), int'(d1), m1_q, m1_cnt, m1_wv);
    check_all();
  endtask

  initial begin
    // Reset state before any edge
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    clear = 1'b1;

    // Shift up 1,0,1,1
    step(2'b01, 1'b1, 1'b0, 4'h0); check("up_cnt1", 32'(cnt4), 32'd1); check("up_wv1", 32'(wv4), 32'd0);
    step(2'b01, 1'b0, 1'b0, 4'h0); check("up_cnt2", 32'(cnt4), 32'd2);
    step(2'b01, 1'b1, 1'b0, 4'h0); check("up_cnt3", 32'(cnt4), 32'd3); check("up_wv3", 32'(wv4), 32'd0);
    step(2'b01, 1'b1, 1'b0, 4'h0);
    check("up_q", 32'(q4), 32'hB); check("up_cnt0", 32'(cnt4), 32'd0);
    check("up_wv4", 32'(wv4), 32'd1); check("up_sout", 32'(sout_up4), 32'd1);

    // Load A then shift down with zeros
    step(2'b11, 1'b0, 1'b0, 4'hA); check("ld_q", 32'(q4), 32'hA); check("ld_wv", 32'(wv4), 32'd0);
    check("ld_sdn", 32'(sout_dn4), 32'd0);
    step(2'b10, 1'b0, 1'b0, 4'h0); check("dn_q1", 32'(q4), 32'h5); check("dn_sdn1", 32'(sout_dn4), 32'd1);
    step(2'b10, 1'b0, 1'b0, 4'h0); check("dn_q2", 32'(q4), 32'h2); check("dn_sdn2", 32'(sout_dn4), 32'd0);
    check("dn_cnt", 32'(cnt4), 32'd2); check("dn_wv", 32'(wv4), 32'd0);

    // Hold and mixed direction from a fresh word
    step(2'b11, 1'b0, 1'b0, 4'h3);
    step(2'b01, 1'b1, 1'b0, 4'h0);
    step(2'b01, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b1, 1'b1, 4'hF);
      check("hold_cnt", 32'(cnt4), 32'd2); check("hold_wv", 32'(wv4), 32'd0);
    end
    step(2'b10, 1'b0, 1'b1, 4'h0); check("mix_wv3", 32'(wv4), 32'd0);
    step(2'b10, 1'b0, 1'b0, 4'h0); check("mix_wv4", 32'(wv4), 32'd1);
    step(2'b00, 1'b0, 1'b0, 4'h0); check("mix_hold_wv", 32'(wv4), 32'd0);

    // Load abort at count 3
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0, 4'h0);
    check("abort_cnt3", 32'(cnt4), 32'd3);
    step(2'b11, 1'b0, 1'b0, 4'h5);
    check("abort_q", 32'(q4), 32'h5); check("abort_cnt", 32'(cnt4), 32'd0); check("abort_wv", 32'(wv4), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 1'b1, 1'b1, 4'h0); check("abort_nowv", 32'(wv4), 32'd0);
    end
    step(2'b01, 1'b0, 1'b0, 4'h0); check("abort_wv4", 32'(wv4), 32'd1);

    // Asynchronous clear mid-word, between edges
    step(2'b01, 1'b1, 1'b0, 4'h0);
    step(2'b01, 1'b1, 1'b0, 4'h0);
    clear = 1'b0;
    #1;
    model_reset();
    check("rst_q", 32'(q4), 32'h0); check("rst_cnt", 32'(cnt4), 32'd0); check("rst_wv", 32'(wv4), 32'd0);
    check_all();
    #1;
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b1, 1'b0, 4'h0); check("rst_nowv", 32'(wv4), 32'd0);
    end
    step(2'b01, 1'b1, 1'b0, 4'h0); check("rst_wv4", 32'(wv4), 32'd1);

    // N=1: every shift completes a word
    mode1 = 2'b01;
    sup1 = 1'b1; step(2'b00, 1'b0, 1'b0, 4'h0); check("n1_q_a", 32'(q1), 32'd1); check("n1_wv_a", 32'(wv1), 32'd1);
    sup1 = 1'b0; step(2'b00, 1'b0, 1'b0, 4'h0); check("n1_q_b", 32'(q1), 32'd0); check("n1_wv_b", 32'(wv1), 32'd1);
    sup1 = 1'b1; step(2'b00, 1'b0, 1'b0, 4'h0); check("n1_q_c", 32'(q1), 32'd1); check("n1_wv_c", 32'(wv1), 32'd1);
    check("n1_cnt", 32'(cnt1), 32'd0);
    mode1 = 2'b00;
    step(2'b00, 1'b0, 1'b0, 4'h0); check("n1_hold_wv", 32'(wv1), 32'd0);

    // Randomised traffic on both instances
    for (int i = 0; i < 300; i++) begin
      mode1 = 2'($urandom_range(3));
      sup1  = 1'($urandom);
      sdn1  = 1'($urandom);
      d1    = 1'($urandom);
      step(2'($urandom_range(3)), 1'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
